// File: rtl/fifo_rd_stream_adapter_pkg.sv
// fifo_rd_stream_adapter shared definitions.
// Pointer sizing and FIFO read latency mapping.
package fifo_rd_stream_adapter_pkg;

  // clog2 that never returns zero, so a
  // one- or two-entry store still gets a bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // generic_fifo_sync read latency from REGOUT.
  function automatic int rd_lat(input int regout);
    return 1 + regout;
  endfunction

  localparam int REGOUT_DEF = 1;
  localparam int RD_LAT_DEF = rd_lat(REGOUT_DEF);

endpackage

// File: rtl/fifo_rd_stream_adapter_if.sv
// FIFO read port plus valid/ready stream.
// master = adapter side, slave = environment.
interface fifo_rd_stream_adapter_if #(
  parameter int WIDTH = 8
);

  logic             fifo_rd_en;
  logic [WIDTH-1:0] fifo_rd_data;
  logic             fifo_empty;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    output fifo_rd_en,
    input  fifo_rd_data,
    input  fifo_empty,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_rd_data,
    output fifo_empty,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/fifo_rd_stream_adapter_stream_buf.sv
// Circular skid store behind the FIFO read port.
// Depth need not be a power of two.
module fifo_rd_stream_adapter_stream_buf
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] head
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = ptr_w(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid = (count != '0);
  assign head  = valid ? mem[rd_ptr] : '0;

  // Pointers and occupancy; flush drops all.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        assert (count < CW'(DEPTH));
        wr_ptr <= nxt(wr_ptr);
      end
      if (pop) rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fifo_rd_stream_adapter.sv
// FIFO read port to valid/ready stream adapter.
// Credits cover buffered plus in-flight words.
module fifo_rd_stream_adapter
  import fifo_rd_stream_adapter_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  fifo_rd_stream_adapter_if.master io
);

  localparam int BUF_DEPTH = RD_LAT + 2;
  localparam int CW        = ptr_w(BUF_DEPTH + 1);

  logic [RD_LAT-1:0] vld_pipe;
  logic [CW-1:0]     cnt;
  logic              live_q;
  logic              rd_en;
  logic              capture;
  logic              pop;
  logic              m_valid;
  logic [WIDTH-1:0]  head;

  // live_q keeps the read strobe idle for the
  // first cycle after reset or flush, while the
  // FIFO flags are still coming out of reset.
  assign rd_en = !io.fifo_empty && !clr && rst_n
              && live_q && (cnt < CW'(BUF_DEPTH));

  assign capture = vld_pipe[RD_LAT-1];
  assign pop     = m_valid && io.m_ready;

  assign io.fifo_rd_en = rd_en;
  assign io.m_valid    = m_valid;
  assign io.m_data     = head;

  // Out-of-reset flag gating the read strobe.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) live_q <= 1'b0;
    else               live_q <= 1'b1;
  end

  // Read tag pipe; zeroing it discards late data.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) vld_pipe <= '0;
    else vld_pipe <= (vld_pipe << 1) | RD_LAT'(rd_en);
  end

  // Credit count: buffered + in-flight words.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
    end else begin
      assert (cnt <= CW'(BUF_DEPTH));
      cnt <= cnt + CW'(rd_en) - CW'(pop);
    end
  end

  fifo_rd_stream_adapter_stream_buf #(
    .WIDTH (WIDTH),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (capture),
    .din   (io.fifo_rd_data),
    .pop   (pop),
    .valid (m_valid),
    .head  (head)
  );

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter.
// FIFO model with RD_LAT=2 and a scoreboard.
module tb_fifo_rd_stream_adapter;

  localparam int W  = 8;
  localparam int RL = 2;
  localparam int BD = RL + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;
  bit   mon_on = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;

  logic [W-1:0] fifo_q [$];
  logic [W-1:0] sb_q   [$];
  logic [W-1:0] pipe   [RL] = '{default: '0};

  fifo_rd_stream_adapter_if #(.WIDTH(W)) io();

  fifo_rd_stream_adapter #(
    .WIDTH  (W),
    .RD_LAT (RL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .io    (io)
  );

  always #5 clk = ~clk;

  // FIFO model: registered empty, RL-cycle data.
  always @(posedge clk) begin
    logic [W-1:0] w;
    w = 8'hEE;
    if (io.fifo_rd_en && fifo_q.size() != 0)
      w = fifo_q.pop_front();
    if (clr) fifo_q.delete();
    for (int i = RL - 1; i > 0; i--)
      pipe[i] <= pipe[i-1];
    pipe[0] <= w;
    io.fifo_empty <= (fifo_q.size() == 0);
  end

  assign io.fifo_rd_data = pipe[RL-1];

  // Monitor: invariants and scoreboard pops.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_on) begin
      n_tests++;
      assert (!(io.fifo_rd_en && io.fifo_empty))
      else begin
        n_fail++;
        $error("FAIL rd_while_empty: rd_en=%0b, required 0",
               io.fifo_rd_en);
      end
      n_tests++;
      assert (dut.cnt <= BD) else begin
        n_fail++;
        $error("FAIL cnt_max: cnt=%0d, required <= %0d",
               dut.cnt, BD);
      end
      if (io.m_valid && io.m_ready) begin
        n_out++;
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $error("FAIL sb_extra: got %h, required none",
                 io.m_data);
        end else begin
          e = sb_q.pop_front();
          assert (io.m_data === e) else begin
            n_fail++;
            $error("FAIL sb_data: got %h, required %h",
                   io.m_data, e);
          end
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [W-1:0] w);
    fifo_q.push_back(w);
    sb_q.push_back(w);
  endtask

  initial begin
    int base;
    int pushed;
    int cyc;
    io.m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) push(W'(i));

    // reset held three edges
    repeat (3) begin
      tick();
      #1;
      check("rst_rd_en", 32'(io.fifo_rd_en), 0);
      check("rst_valid", 32'(io.m_valid), 0);
      check("rst_data", 32'(io.m_data), 0);
    end
    rst_n  = 1'b1;
    mon_on = 1'b1;
    #1;
    check("rel_rd_en", 32'(io.fifo_rd_en), 0);
    check("rel_valid", 32'(io.m_valid), 0);

    // streaming, m_ready=1
    for (int k = 1; k <= 21; k++) begin
      tick();
      #1;
      check("str_rd_en", 32'(io.fifo_rd_en),
            32'(k <= 16));
      check("str_valid", 32'(io.m_valid),
            32'(k >= 4 && k <= 19));
      if (k >= 4 && k <= 19)
        check("str_data", 32'(io.m_data), k - 3);
    end
    check("str_count", n_out, 16);

    // backpressure
    tick();
    io.m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) push(W'(i));
    for (int k = 1; k <= 12; k++) begin
      tick();
      #1;
      check("bp_rd_en", 32'(io.fifo_rd_en),
            32'(k <= 4));
      check("bp_valid", 32'(io.m_valid),
            32'(k >= 4));
      if (k >= 4)
        check("bp_hold", 32'(io.m_data), 1);
    end
    for (int k = 13; k <= 29; k++) begin
      tick();
      if (k == 13) io.m_ready = 1'b1;
      #1;
      check("bp_drain_v", 32'(io.m_valid),
            32'(k <= 28));
      if (k <= 28)
        check("bp_drain_d", 32'(io.m_data), k - 12);
    end
    check("bp_count", n_out, 32);

    // single last word
    tick();
    push(8'hA5);
    for (int k = 1; k <= 6; k++) begin
      tick();
      #1;
      check("last_rd_en", 32'(io.fifo_rd_en),
            32'(k == 1));
      check("last_valid", 32'(io.m_valid),
            32'(k == 4));
      if (k == 4)
        check("last_data", 32'(io.m_data), 32'hA5);
    end
    check("last_count", n_out, 33);

    // flush with reads in flight
    tick();
    io.m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(W'(8'h20 + i));
    for (int k = 1; k <= 3; k++) begin
      tick();
      #1;
      check("clr_fill_rd", 32'(io.fifo_rd_en), 1);
    end
    tick();
    clr = 1'b1;
    #1;
    check("clr_pre_v", 32'(io.m_valid), 1);
    check("clr_pre_d", 32'(io.m_data), 32'h20);
    check("clr_inflight", 32'(dut.vld_pipe), 3);
    check("clr_pre_cnt", 32'(dut.cnt), 3);
    check("clr_rd_gate", 32'(io.fifo_rd_en), 0);
    sb_q.delete();
    tick();
    clr = 1'b0;
    #1;
    check("clr_cnt", 32'(dut.cnt), 0);
    check("clr_rd_en", 32'(io.fifo_rd_en), 0);
    for (int k = 5; k <= 8; k++) begin
      if (k > 5) begin
        tick();
        #1;
      end
      check("clr_valid", 32'(io.m_valid), 0);
    end
    io.m_ready = 1'b1;
    push(8'h30);
    push(8'h31);
    for (int k = 9; k <= 14; k++) begin
      tick();
      #1;
      check("rf_rd_en", 32'(io.fifo_rd_en),
            32'(k == 9 || k == 10));
      check("rf_valid", 32'(io.m_valid),
            32'(k == 12 || k == 13));
      if (k == 12 || k == 13)
        check("rf_data", 32'(io.m_data),
              32'h30 + k - 12);
    end
    check("rf_count", n_out, 35);

    // random stress
    base   = n_out;
    pushed = 0;
    cyc    = 0;
    while ((n_out - base < 500) && cyc < 8000) begin
      tick();
      cyc++;
      io.m_ready = 1'($urandom_range(0, 1));
      if (pushed < 500 && $urandom_range(0, 9) < 6) begin
        push(W'($urandom));
        pushed++;
      end
    end
    tick();
    io.m_ready = 1'b1;
    repeat (10) tick();
    check("stress_count", n_out - base, 500);
    check("stress_sb_left", sb_q.size(), 0);
    check("stress_idle_v", 32'(io.m_valid), 0);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
